// File: rtl/hi_lo_muldiv_controller_if.sv
// Decode-stage <-> HI/LO unit bundle: the instruction with its operands, plus stall/busy/register views.
interface hi_lo_muldiv_controller_if;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] read_data;

    modport master (
        output op_valid, funct, rs_value, rt_value,
        input  stall, busy, hi, lo, read_data
    );

    modport slave (
        input  op_valid, funct, rs_value, rt_value,
        output stall, busy, hi, lo, read_data
    );
endinterface

// File: rtl/hi_lo_muldiv_controller.sv
// HI/LO sequencer: iterative mul/div (32 BUSY cycles; 1 for MUL_FAST multiply), MTxx/MFxx handled when idle.
// Backpressure: any HI/LO-class instruction arriving while BUSY raises a combinational stall and is not accepted.
module hi_lo_muldiv_controller #(
    parameter bit MUL_FAST = 1'b0
) (
    input logic                      clk,
    input logic                      reset,
    hi_lo_muldiv_controller_if.slave bus
);
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [4:0] MUL_CNT = MUL_FAST ? 5'd0 : 5'd31;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q;
    logic [63:0] acc_q;      // mul: partial product; div: remainder in [31:0]
    logic [63:0] mcand_q;    // mul: shifting multiplicand; div: divisor in [31:0]
    logic [31:0] mplier_q;   // mul: shifting multiplier; div: dividend in, quotient out
    logic        neg_lo_q, neg_hi_q, div_zero_q;
    logic [31:0] hi_q, lo_q;

    logic        start_mul, start_div, is_hilo, accept, signed_op, last;
    logic [31:0] abs_rs, abs_rt;
    logic [63:0] mul_acc_next, mul_raw, mul_res;
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] rem_next, quot_next, quot_res, rem_res;

    always_comb begin
        start_mul = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
        start_div = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
        is_hilo   = start_mul || start_div ||
                    (bus.funct == F_MTHI) || (bus.funct == F_MTLO) ||
                    (bus.funct == F_MFHI) || (bus.funct == F_MFLO);
        accept    = bus.op_valid && (state_q == S_IDLE);
        signed_op = (bus.funct == F_MULT) || (bus.funct == F_DIV);
        abs_rs    = (signed_op && bus.rs_value[31]) ? (32'd0 - bus.rs_value) : bus.rs_value;
        abs_rt    = (signed_op && bus.rt_value[31]) ? (32'd0 - bus.rt_value) : bus.rt_value;
        last      = (count_q == 5'd0);

        mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
        mul_raw      = MUL_FAST ? ({32'd0, mcand_q[31:0]} * {32'd0, mplier_q}) : mul_acc_next;
        mul_res      = neg_lo_q ? (64'd0 - mul_raw) : mul_raw;

        // Restoring step: bring in the next dividend bit, subtract if it fits
        rem_sh    = {acc_q[31:0], mplier_q[31]};
        div_ge    = (rem_sh >= {1'b0, mcand_q[31:0]});
        rem_next  = div_ge ? 32'(rem_sh - {1'b0, mcand_q[31:0]}) : rem_sh[31:0];
        quot_next = {mplier_q[30:0], div_ge};
        quot_res  = div_zero_q ? 32'hFFFF_FFFF : (neg_lo_q ? (32'd0 - quot_next) : quot_next);
        rem_res   = neg_hi_q ? (32'd0 - rem_next) : rem_next;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && start_mul)      state_d = S_MUL;
                else if (accept && start_div) state_d = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= 5'd0;
            acc_q      <= 64'd0;
            mcand_q    <= 64'd0;
            mplier_q   <= 32'd0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else if (state_q == S_IDLE) begin
            if (accept && start_mul) begin
                count_q  <= MUL_CNT;
                acc_q    <= 64'd0;
                mcand_q  <= {32'd0, abs_rs};
                mplier_q <= abs_rt;
                neg_lo_q <= signed_op && (bus.rs_value[31] ^ bus.rt_value[31]);
                neg_hi_q <= 1'b0;
            end else if (accept && start_div) begin
                count_q    <= 5'd31;
                acc_q      <= 64'd0;
                mcand_q    <= {32'd0, abs_rt};
                mplier_q   <= abs_rs;
                neg_lo_q   <= signed_op && (bus.rs_value[31] ^ bus.rt_value[31]);
                neg_hi_q   <= signed_op && bus.rs_value[31];
                div_zero_q <= (bus.rt_value == 32'd0);
            end else if (accept && bus.funct == F_MTHI) begin
                hi_q <= bus.rs_value;
            end else if (accept && bus.funct == F_MTLO) begin
                lo_q <= bus.rs_value;
            end
        end else begin
            if (!last) count_q <= count_q - 5'd1;
            if (state_q == S_MUL) begin
                acc_q    <= mul_acc_next;
                mcand_q  <= {mcand_q[62:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[31:1]};
                if (last) begin
                    hi_q <= mul_res[63:32];
                    lo_q <= mul_res[31:0];
                end
            end else begin
                acc_q    <= {32'd0, rem_next};
                mplier_q <= quot_next;
                if (last) begin
                    hi_q <= rem_res;
                    lo_q <= quot_res;
                end
            end
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.stall     = bus.op_valid && is_hilo && (state_q != S_IDLE);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.read_data = (bus.funct == F_MFHI) ? hi_q :
                           (bus.funct == F_MFLO) ? lo_q : 32'd0;
endmodule
